// File: rtl/fft_stream_adapter.sv
// -----------------------------------------------------------------------------
// fft_stream_adapter
//
// Purpose:
//   Streaming wrapper around a parallel N-point FFT core. Serial complex input
//   samples are gathered into one flat frame and handed to the core with a
//   one-cycle start pulse. The adapter then waits for the core's done pulse,
//   captures the parallel result and streams it out one bin per beat with a
//   last marker. A frame whose core result never arrives within
//   TIMEOUT_CYCLES is dropped and flagged with a sticky timeout bit.
//
// Configuration macro:
//   FFT_ADAPT_BITREV_EN - when defined, bins are emitted in bit-reversed index
//                         order and o_m_index reports the true bin index.
//                         When undefined, bins are emitted in natural order.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_s_valid/o_s_ready          input sample handshake (ready only in FILL)
//   i_s_re, i_s_im               input sample components
//   o_fft_re, o_fft_im           flat frame to core, element k at [k*W +: W]
//   o_fft_start                  one-cycle pulse, frame valid for the core
//   i_fft_re, i_fft_im           flat result from core, same packing
//   i_fft_done                   core done pulse (honoured only in WAIT)
//   o_m_valid/i_m_ready          output bin handshake
//   o_m_re, o_m_im, o_m_index    output bin data and its bin index
//   o_m_last                     high with the final bin of a frame
//   o_timeout                    sticky: some frame was abandoned
//   o_frame_cnt                  frames fully drained, wraps at 16 bits
// -----------------------------------------------------------------------------
module fft_stream_adapter #(
  parameter int WORD_SIZE      = 16,
  parameter int FRACTION       = 8,
  parameter int N_POINTS       = 16,
  parameter int LOG2N          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_s_valid,
  output logic                          o_s_ready,
  input  logic [WORD_SIZE-1:0]          i_s_re,
  input  logic [WORD_SIZE-1:0]          i_s_im,
  output logic [N_POINTS*WORD_SIZE-1:0] o_fft_re,
  output logic [N_POINTS*WORD_SIZE-1:0] o_fft_im,
  output logic                          o_fft_start,
  input  logic [N_POINTS*WORD_SIZE-1:0] i_fft_re,
  input  logic [N_POINTS*WORD_SIZE-1:0] i_fft_im,
  input  logic                          i_fft_done,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [WORD_SIZE-1:0]          o_m_re,
  output logic [WORD_SIZE-1:0]          o_m_im,
  output logic [LOG2N-1:0]              o_m_index,
  output logic                          o_m_last,
  output logic                          o_timeout,
  output logic [15:0]                   o_frame_cnt
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int FRAME_W = N_POINTS * WORD_SIZE;
  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N_POINTS - 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  // Parameter sanity: FRACTION only documents the Q format, so it merely has
  // to fit in a word; the index width must describe the frame length exactly.
  if (FRACTION >= WORD_SIZE) begin : g_bad_fraction
    $error("fft_stream_adapter: FRACTION must be smaller than WORD_SIZE");
  end
  if (N_POINTS != (1 << LOG2N)) begin : g_bad_log2n
    $error("fft_stream_adapter: N_POINTS must equal 2**LOG2N");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fft_stream_adapter: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]           r_state;
  logic [LOG2N-1:0]     r_wr_idx;
  logic [LOG2N-1:0]     r_rd_idx;
  logic [TIMER_W-1:0]   r_timer;
  logic [FRAME_W-1:0]   r_fft_re;
  logic [FRAME_W-1:0]   r_fft_im;
  logic [FRAME_W-1:0]   r_cap_re;
  logic [FRAME_W-1:0]   r_cap_im;
  logic                 r_timeout;
  logic [15:0]          r_frame_cnt;
  logic [LOG2N-1:0]     w_rd_order;

`ifdef FFT_ADAPT_BITREV_EN
  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  assign w_rd_order = f_bitrev(r_rd_idx);
`else
  assign w_rd_order = r_rd_idx;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FILL;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_timer     <= '0;
      r_fft_re    <= '0;
      r_fft_im    <= '0;
      r_cap_re    <= '0;
      r_cap_im    <= '0;
      r_timeout   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (i_s_valid) begin
            r_fft_re[r_wr_idx*WORD_SIZE +: WORD_SIZE] <= i_s_re;
            r_fft_im[r_wr_idx*WORD_SIZE +: WORD_SIZE] <= i_s_im;
            if (r_wr_idx == IDX_LAST) begin
              r_wr_idx <= '0;
              r_state  <= S_START;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end
        S_START: begin
          // Done is deliberately not looked at here: the core cannot have
          // finished a frame it has only just been told about.
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last permitted cycle still wins over the
          // timeout.
          if (i_fft_done) begin
            r_cap_re <= i_fft_re;
            r_cap_im <= i_fft_im;
            r_state  <= S_DRAIN;
          end else if (r_timer == TIMER_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_FILL;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (i_m_ready) begin
            if (r_rd_idx == IDX_LAST) begin
              r_rd_idx    <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= S_FILL;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign o_s_ready   = (r_state == S_FILL);
  assign o_fft_start = (r_state == S_START);
  assign o_fft_re    = r_fft_re;
  assign o_fft_im    = r_fft_im;
  assign o_m_valid   = (r_state == S_DRAIN);
  assign o_m_re      = r_cap_re[w_rd_order*WORD_SIZE +: WORD_SIZE];
  assign o_m_im      = r_cap_im[w_rd_order*WORD_SIZE +: WORD_SIZE];
  assign o_m_index   = w_rd_order;
  assign o_m_last    = (r_state == S_DRAIN) && (r_rd_idx == IDX_LAST);
  assign o_timeout   = r_timeout;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fft_stream_adapter
//
// Bench for fft_stream_adapter with a loopback core stub: the core result is
// the frame the adapter presents, and done pulses D cycles after start.
// Expected output bins are queued when a frame is issued; a monitor on the
// falling edge compares every presented bin against the queue head and pops
// it on an accepted beat. With FFT_ADAPT_BITREV_EN defined the bench uses
// N_POINTS=8 and expects bit-reversed emission order.
// -----------------------------------------------------------------------------
module tb_fft_stream_adapter;

`ifdef FFT_ADAPT_BITREV_EN
  localparam int N = 8;
  localparam int L = 3;
`else
  localparam int N = 16;
  localparam int L = 4;
`endif
  localparam int W  = 16;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W-1:0]     s_re = '0;
  logic [W-1:0]     s_im = '0;
  logic [N*W-1:0]   fft_re_o, fft_im_o;
  logic             fft_start;
  logic [N*W-1:0]   fft_re_i, fft_im_i;
  logic             fft_done;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [W-1:0]     m_re, m_im;
  logic [L-1:0]     m_index;
  logic             m_last;
  logic             timeout;
  logic [15:0]      frame_cnt;

  always #5 clk = ~clk;

  fft_stream_adapter #(
    .WORD_SIZE(W), .FRACTION(8), .N_POINTS(N), .LOG2N(L), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_re(s_re), .i_s_im(s_im),
    .o_fft_re(fft_re_o), .o_fft_im(fft_im_o), .o_fft_start(fft_start),
    .i_fft_re(fft_re_i), .i_fft_im(fft_im_i), .i_fft_done(fft_done),
    .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_re(m_re), .o_m_im(m_im), .o_m_index(m_index), .o_m_last(m_last),
    .o_timeout(timeout), .o_frame_cnt(frame_cnt)
  );

  // Loopback core stub
  int   D = 5;
  int   stub_cnt = 0;
  logic spur = 1'b0;
  assign fft_re_i = fft_re_o;
  assign fft_im_i = fft_im_o;
  always @(posedge clk) begin
    if (fft_start) stub_cnt <= D;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end
  assign fft_done = (stub_cnt == 1) | spur;

  // Output ready pattern: steady high, or toggling every cycle
  bit tog = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tog) m_ready = ~m_ready;
    else     m_ready = 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard
  logic [W-1:0] q_re[$];
  logic [W-1:0] q_im[$];
  logic [L-1:0] q_idx[$];
  logic         q_last[$];

  function automatic int order(input int j);
`ifdef FFT_ADAPT_BITREV_EN
    int r = 0;
    for (int b = 0; b < L; b++) if (((j >> b) & 1) != 0) r |= 1 << (L - 1 - b);
    return r;
`else
    return j;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (q_re.size() == 0) begin
        chk("unexpected_bin", 64'(m_index), 64'hFFFF);
      end else begin
        chk("bin_re",    64'(m_re),    64'(q_re[0]));
        chk("bin_im",    64'(m_im),    64'(q_im[0]));
        chk("bin_index", 64'(m_index), 64'(q_idx[0]));
        chk("bin_last",  64'(m_last),  64'(q_last[0]));
        if (m_ready) begin
          void'(q_re.pop_front());
          void'(q_im.pop_front());
          void'(q_idx.pop_front());
          void'(q_last.pop_front());
        end
      end
    end
  end

  // Sends nb samples re=re0+k*rs, im=im0+k*is; returns just after the edge
  // that accepted the final sample.
  task automatic send_frame(input int re0, input int rs, input int im0, input int is,
                            input bit push, input int nb, input bit gap, input bit spur_fill);
    int t;
    if (push) begin
      for (int j = 0; j < N; j++) begin
        int idx = order(j);
        q_re.push_back(W'(re0 + idx * rs));
        q_im.push_back(W'(im0 + idx * is));
        q_idx.push_back(L'(idx));
        q_last.push_back(j == N - 1);
      end
    end
    for (int k = 0; k < nb; k++) begin
      if (gap && (k % 3 == 1)) begin
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (spur_fill) spur = 1'b1;
      end
      t = 0;
      do begin
        @(posedge clk); #1;
        spur    = 1'b0;
        s_valid = 1'b1;
        s_re    = W'(re0 + k * rs);
        s_im    = W'(im0 + k * is);
        t++;
      end while (!s_ready && t < 300);
      if (t >= 300) chk("s_ready_wait", 64'(s_ready), 64'd1);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Counts edges from the last input beat to the first o_m_valid.
  task automatic measure(input string name, input bit spur_start);
    int k = 0;
    chk({name, "_start_pulse"}, 64'(fft_start), 64'd1);
    while (!m_valid && k < 500) begin
      if (k == 0 && spur_start) spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      k++;
      if (k == 1) chk({name, "_start_one_cycle"}, 64'(fft_start), 64'd0);
    end
    chk({name, "_latency"}, 64'(k), 64'(D + 1));
  endtask

  task automatic wait_drain(input string name, input int exp_cnt);
    int t = 0;
    while (!(frame_cnt == 16'(exp_cnt) && s_ready) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
    chk({name, "_queue_empty"}, 64'(q_re.size()), 64'd0);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_s_ready",   64'(s_ready),   64'd1);
    chk("rst_start",     64'(fft_start), 64'd0);
    chk("rst_m_valid",   64'(m_valid),   64'd0);
    chk("rst_m_last",    64'(m_last),    64'd0);
    chk("rst_timeout",   64'(timeout),   64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_fft_re",    64'(|fft_re_o), 64'd0);

    // 1: basic frame, re=k*0x100, im=-k*0x100, D=5
    D = 5;
    send_frame(0, 256, 0, -256, 1'b1, N, 1'b0, 1'b0);
    measure("t1", 1'b0);
    wait_drain("t1", 1);

    // 2: same frame with input gaps and toggling output ready
    tog = 1'b1;
    send_frame(0, 256, 0, -256, 1'b1, N, 1'b1, 1'b0);
    measure("t2", 1'b0);
    wait_drain("t2", 2);
    tog = 1'b0;

    // 3: core never answers in time
    D = TO + 5;
    send_frame(0, 256, 0, -256, 1'b0, N, 1'b0, 1'b0);
    k = 0;
    while (!s_ready && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t3_timeout_cycles", 64'(k), 64'(TO + 1));
    chk("t3_timeout_flag", 64'(timeout), 64'd1);
    chk("t3_frame_cnt_held", 64'(frame_cnt), 64'd2);
    repeat (10) @(posedge clk);
    #1;
    D = 3;
    send_frame(16'h0700, 16'h0011, 5, 7, 1'b1, N, 1'b0, 1'b0);
    measure("t3b", 1'b0);
    wait_drain("t3b", 3);
    chk("t3_timeout_sticky", 64'(timeout), 64'd1);

    // 4: reset after 7 beats, then a clean frame
    D = 5;
    send_frame(16'h5500, 1, 16'h6600, 1, 1'b0, 7, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t4_s_ready",   64'(s_ready),   64'd1);
    chk("t4_timeout",   64'(timeout),   64'd0);
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("t4_fft_re",    64'(|fft_re_o), 64'd0);
    send_frame(16'h1234, 16'h0011, -3, 2, 1'b1, N, 1'b0, 1'b0);
    measure("t4", 1'b0);
    wait_drain("t4", 1);

    // 6: spurious done pulses during FILL and in the START cycle
    D = 6;
    send_frame(16'h8000, 16'h0101, 16'h7FFF, -1, 1'b1, N, 1'b1, 1'b1);
    measure("t6", 1'b1);
    wait_drain("t6", 2);

    repeat (5) @(posedge clk);
    chk("end_queue_empty", 64'(q_re.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
